print_job_scheduler: RTL and testbench

Shares one copier/printer engine among NREQ requesters using round-robin arbitration. Latches the winner's page count and issues one page at a time to the engine with a start/done handshake. Pauses on paper-out or jam faults and reissues the interrupted page on recovery. Sits between board-level request sources (SWI-derived) and the copier engine FSM; status goes to LED/SEG.

---
 rtl/print_sched_pkg.sv | 36 +++
 rtl/print_job_scheduler_if.sv | 30 +++
 rtl/print_job_scheduler_rr_arbiter.sv | 26 ++
 rtl/print_job_scheduler.sv | 150 +++++++++++++++
 tb/tb_print_job_scheduler.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/print_sched_pkg.sv
// Shared types and display constants for the print job scheduler.
package print_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FAULT = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    localparam int unsigned SEG_W = 7;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_IDLE  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_ISSUE = 7'h06;
    localparam logic [SEG_W-1:0] SEG_WAIT  = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_FAULT = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_DONE  = 7'h66;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    function automatic logic [SEG_W-1:0] state_seg(input sched_state_t s);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (s)
            S_IDLE:  seg = SEG_IDLE;
            S_ISSUE: seg = SEG_ISSUE;
            S_WAIT:  seg = SEG_WAIT;
            S_FAULT: seg = SEG_FAULT;
            S_DONE:  seg = SEG_DONE;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/print_job_scheduler_if.sv
// Requester and engine signal bundle around the print job scheduler.
interface print_job_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned QBITS = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*QBITS-1:0] qty;
    logic                  cancel;
    logic                  eng_ready;
    logic                  eng_page_done;
    logic                  eng_no_paper;
    logic                  eng_jam;
    logic                  eng_start;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [QBITS-1:0]      remaining;
    logic                  fault_paper;
    logic                  fault_jam;
    logic [2:0]            state_o;

    modport master (
        output req, qty, cancel, eng_ready, eng_page_done, eng_no_paper, eng_jam,
        input  eng_start, grant, ack, remaining, fault_paper, fault_jam, state_o
    );

    modport slave (
        input  req, qty, cancel, eng_ready, eng_page_done, eng_no_paper, eng_jam,
        output eng_start, grant, ack, remaining, fault_paper, fault_jam, state_o
    );
endinterface

// File: rtl/print_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request above the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(pointer) + i) % NREQ;
            if (!valid && req[PW'(idx)]) begin
                win[PW'(idx)] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/print_job_scheduler.sv
// Round-robin owner of one print engine; issues pages one at a time and
// pauses/reissues on paper-out or jam.
module print_job_scheduler
    import print_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned QBITS = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    print_job_scheduler_if.slave  bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t     state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             start_q, start_d;
    logic [QBITS-1:0] rem_q, rem_d;
    logic             fpaper_q, fpaper_d;
    logic             fjam_q, fjam_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;

    logic [NREQ-1:0]  arb_win;
    logic             arb_valid;
    logic [PW-1:0]    win_idx;
    logic [QBITS-1:0] win_qty;
    logic             eng_fault;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .pointer (ptr_q),
        .win     (arb_win),
        .valid   (arb_valid)
    );

    // One-hot winner to index, for qty selection and the pointer update
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_win[i]) win_idx = PW'(i);
        end
    end

    assign win_qty   = bus.qty[32'(win_idx)*QBITS +: QBITS];
    assign eng_fault = bus.eng_no_paper | bus.eng_jam;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            rem_q    <= '0;
            fpaper_q <= 1'b0;
            fjam_q   <= 1'b0;
            ptr_q    <= PW'(NREQ - 1);
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            rem_q    <= rem_d;
            fpaper_q <= fpaper_d;
            fjam_q   <= fjam_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        start_d = 1'b0;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;

        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_win;
                    owner_d = win_idx;
                    rem_d   = win_qty;
                    state_d = (win_qty == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.cancel) begin
                    rem_d   = '0;
                    state_d = S_DONE;
                end else if (bus.eng_ready && !eng_fault) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A page finishing alongside a fault still counts
                if (bus.cancel) begin
                    rem_d   = '0;
                    state_d = S_DONE;
                end else if (bus.eng_page_done) begin
                    rem_d = rem_q - QBITS'(1);
                    if (rem_d == '0)    state_d = S_DONE;
                    else if (eng_fault) state_d = S_FAULT;
                    else                state_d = S_ISSUE;
                end else if (eng_fault) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (bus.cancel) begin
                    rem_d   = '0;
                    state_d = S_DONE;
                end else if (!eng_fault) begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                rem_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Ack is present for exactly the single DONE cycle
        if (state_d == S_DONE) ack_d = grant_d;

        fpaper_d = (state_d == S_FAULT) && bus.eng_no_paper;
        fjam_d   = (state_d == S_FAULT) && bus.eng_jam;
    end

    assign bus.eng_start   = start_q;
    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.remaining   = rem_q;
    assign bus.fault_paper = fpaper_q;
    assign bus.fault_jam   = fjam_q;
    assign bus.state_o     = 3'(state_q);

endmodule

// File: tb/tb_print_job_scheduler.sv
// Scoreboard bench for print_job_scheduler: expected start/ack events are
// queued by the stimulus and popped by an independent monitor.
module tb_print_job_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned QBITS = 4;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    logic auto_eng = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Event word: {is_start, grant, ack, remaining}
    logic [12:0] exp_q[$];

    print_job_scheduler_if #(.NREQ(NREQ), .QBITS(QBITS)) bus ();

    print_job_scheduler #(.NREQ(NREQ), .QBITS(QBITS)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_start(input logic [3:0] g, input logic [3:0] r);
        exp_q.push_back({1'b1, g, 4'b0000, r});
    endtask

    task automatic push_ack(input logic [3:0] g);
        exp_q.push_back({1'b0, g, g, 4'b0000});
    endtask

    // Monitor: every eng_start pulse or ack pulse must match the next queued event
    initial begin
        logic [12:0] act;
        logic [12:0] exp;
        forever begin
            @(negedge clk_2);
            if (bus.eng_start || bus.ack != '0) begin
                act = {bus.eng_start, bus.grant, bus.ack, bus.remaining};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %0h with nothing expected at %0t", act, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_bad++;
                        $display("FAIL event: got %0h expected %0h at %0t", act, exp, $time);
                    end
                end
            end
        end
    end

    // Engine responder: page_done two cycles after each start when enabled
    initial begin
        forever begin
            @(negedge clk_2);
            if (auto_eng && bus.eng_start) begin
                @(negedge clk_2);
                bus.eng_page_done = 1'b1;
                @(negedge clk_2);
                bus.eng_page_done = 1'b0;
            end
        end
    end

    task automatic wait_start();
        int k;
        k = 0;
        do begin
            @(negedge clk_2);
            k++;
        end while (!bus.eng_start && k < 60);
        if (!bus.eng_start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_start: got timeout expected eng_start at %0t", $time);
        end
    endtask

    task automatic wait_ack(input bit clear);
        int k;
        k = 0;
        do begin
            @(negedge clk_2);
            k++;
        end while (bus.ack == '0 && k < 80);
        if (bus.ack == '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ack: got timeout expected ack at %0t", $time);
        end else if (clear) begin
            bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk_2);
            k++;
        end while (bus.state_o != 3'd0 && k < 20);
        chk("idle_state", 32'(bus.state_o), 32'd0);
        chk("idle_grant", 32'(bus.grant), 32'd0);
    endtask

    initial begin
        bus.req           = '0;
        bus.qty           = '0;
        bus.cancel        = 1'b0;
        bus.eng_ready     = 1'b1;
        bus.eng_page_done = 1'b0;
        bus.eng_no_paper  = 1'b0;
        bus.eng_jam       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_2);
        chk("reset_outputs",
            32'({bus.grant, bus.ack, bus.eng_start, bus.remaining, bus.fault_paper, bus.fault_jam}), 32'd0);
        chk("reset_state", 32'(bus.state_o), 32'd0);
        reset = 1'b0;

        // Round-robin with req=1011, qty=1 each
        bus.qty = {4'd1, 4'd1, 4'd1, 4'd1};
        push_start(4'b0001, 4'd1); push_ack(4'b0001);
        push_start(4'b0010, 4'd1); push_ack(4'b0010);
        push_start(4'b1000, 4'd1); push_ack(4'b1000);
        push_start(4'b0001, 4'd1); push_ack(4'b0001);
        bus.req = 4'b1011;
        for (int j = 0; j < 3; j++) wait_ack(1'b0);
        wait_ack(1'b1);
        bus.req = '0;
        wait_idle();

        // Single job, three pages
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd3};
        push_start(4'b0001, 4'd3);
        push_start(4'b0001, 4'd2);
        push_start(4'b0001, 4'd1);
        push_ack(4'b0001);
        bus.req = 4'b0001;
        wait_ack(1'b1);
        wait_idle();

        // Paper-out during first page, then reissue
        auto_eng = 1'b0;
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd2};
        push_start(4'b0001, 4'd2);
        push_start(4'b0001, 4'd2);
        push_start(4'b0001, 4'd1);
        push_ack(4'b0001);
        bus.req = 4'b0001;
        wait_start();
        bus.eng_no_paper = 1'b1;
        @(negedge clk_2);
        chk("paper_state", 32'(bus.state_o), 32'd3);
        chk("paper_flags", 32'({bus.fault_paper, bus.fault_jam}), 32'b10);
        chk("paper_remaining", 32'(bus.remaining), 32'd2);
        bus.eng_no_paper = 1'b0;
        auto_eng = 1'b1;
        wait_ack(1'b1);
        chk("paper_flag_clear", 32'(bus.fault_paper), 32'd0);
        wait_idle();

        // page_done + jam on the last page: completes, no fault
        auto_eng = 1'b0;
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd1};
        push_start(4'b0001, 4'd1);
        push_ack(4'b0001);
        bus.req = 4'b0001;
        wait_start();
        bus.eng_page_done = 1'b1;
        bus.eng_jam = 1'b1;
        @(negedge clk_2);
        bus.eng_page_done = 1'b0;
        bus.eng_jam = 1'b0;
        chk("donejam_last_state", 32'(bus.state_o), 32'd4);
        chk("donejam_last_fjam", 32'(bus.fault_jam), 32'd0);
        bus.req = '0;
        wait_idle();

        // page_done + jam with a page left: fault, remaining 1
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd2};
        push_start(4'b0001, 4'd2);
        bus.req = 4'b0001;
        wait_start();
        bus.eng_page_done = 1'b1;
        bus.eng_jam = 1'b1;
        @(negedge clk_2);
        bus.eng_page_done = 1'b0;
        chk("donejam_mid_state", 32'(bus.state_o), 32'd3);
        chk("donejam_mid_remaining", 32'(bus.remaining), 32'd1);
        chk("donejam_mid_fjam", 32'(bus.fault_jam), 32'd1);
        push_start(4'b0001, 4'd1);
        push_ack(4'b0001);
        bus.eng_jam = 1'b0;
        auto_eng = 1'b1;
        wait_ack(1'b1);
        wait_idle();

        // Cancel while faulted with jam held
        auto_eng = 1'b0;
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd5};
        push_start(4'b0001, 4'd5);
        push_ack(4'b0001);
        bus.req = 4'b0001;
        wait_start();
        bus.eng_jam = 1'b1;
        @(negedge clk_2);
        chk("cancel_pre_state", 32'(bus.state_o), 32'd3);
        bus.cancel = 1'b1;
        wait_ack(1'b1);
        bus.cancel = 1'b0;
        chk("cancel_state", 32'(bus.state_o), 32'd4);
        chk("cancel_remaining", 32'(bus.remaining), 32'd0);
        wait_idle();
        repeat (4) @(negedge clk_2);
        bus.eng_jam = 1'b0;
        auto_eng = 1'b1;

        // Zero-length job on requester 2
        bus.qty = {4'd0, 4'd0, 4'd0, 4'd0};
        push_ack(4'b0100);
        bus.req = 4'b0100;
        wait_ack(1'b1);
        wait_idle();

        // Reset in WAIT, then requester 0 wins first again
        auto_eng = 1'b0;
        bus.qty = {4'd1, 4'd1, 4'd1, 4'd3};
        push_start(4'b0001, 4'd3);
        bus.req = 4'b0001;
        wait_start();
        #2 reset = 1'b1;
        #1;
        chk("midreset_outputs",
            32'({bus.grant, bus.ack, bus.eng_start, bus.remaining, bus.fault_paper, bus.fault_jam}), 32'd0);
        chk("midreset_state", 32'(bus.state_o), 32'd0);
        @(negedge clk_2);
        reset = 1'b0;
        auto_eng = 1'b1;
        bus.qty = {4'd1, 4'd1, 4'd1, 4'd1};
        push_start(4'b0001, 4'd1);
        push_ack(4'b0001);
        bus.req = 4'b1111;
        wait_ack(1'b0);
        bus.req = '0;
        wait_idle();

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk_2);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
